// File: rtl/ldpc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ldpc_pkg
//  Brief    : Shared types and constants for the LDPC iteration controller.
//             Holds the sequencer state encoding, iteration defaults, and the
//             phase latencies the datapath is built around.
//  Revision : 1.0  initial release
// ============================================================================
package ldpc_pkg;

    // Iteration defaults. The counter must hold MAX_ITER without wrapping.
    localparam int unsigned c_max_iter = 16;
    localparam int unsigned c_iter_w   = 5;

    // Phase latencies in clock cycles; the datapath pipelines match these.
    localparam int unsigned c_cnu_lat  = 4;
    localparam int unsigned c_vnu_lat  = 3;
    localparam int unsigned c_par_lat  = 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_CNU  = 3'd2,
        S_VNU  = 3'd3,
        S_CHK  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    // Width of a down-counter that must hold (largest latency - 1).
    function automatic int unsigned phase_cnt_w(input int unsigned a,
                                                input int unsigned b,
                                                input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ldpc_phase_timer.sv
`default_nettype none
// ============================================================================
//  Module   : ldpc_phase_timer
//  Brief    : Loadable down-counter with a zero flag. Loading N-1 on the cycle
//             before a phase starts makes the phase last exactly N cycles.
//  Ports    : clk        clock, rising edge
//             rst        synchronous active-high reset
//             i_load     load i_load_val (priority over counting)
//             i_load_val value to load
//             o_zero     counter is zero (last cycle of the current phase)
//  Revision : 1.0  initial release
// ============================================================================
module ldpc_phase_timer #(
    parameter int unsigned CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/ldpc_iter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ldpc_iter_ctrl
//  Brief    : Iteration sequencer for the LDPC min-sum decoder. Accepts a
//             frame, pulses load_en, then repeats CNU / VNU / parity-check
//             phases until the iteration limit (or, optionally, the first
//             passing parity check) and presents success + iteration count.
//  Config   : LDPC_EARLY_TERM_EN - when defined, decoding stops at the first
//             iteration whose parity check passes.
//  Ports    : clk, xrst (sync, active-high)
//             i_val/i_rdy        frame handshake, cfg_max_iter sampled on accept
//             load_en/cnu_en/vnu_en  datapath phase enables
//             parity_ok          hard-decision parity result (used in CHK only)
//             roop               current 0-based iteration index
//             o_val/o_rdy        result handshake, o_success/o_iter held
//  Revision : 1.0  initial release
// ============================================================================
module ldpc_iter_ctrl
    import ldpc_pkg::*;
#(
    parameter int unsigned MAX_ITER = c_max_iter,
    parameter int unsigned ITER_W   = c_iter_w,
    parameter int unsigned CNU_LAT  = c_cnu_lat,
    parameter int unsigned VNU_LAT  = c_vnu_lat,
    parameter int unsigned PAR_LAT  = c_par_lat
) (
    input  logic              clk,
    input  logic              xrst,
    input  logic              i_val,
    output logic              i_rdy,
    input  logic [ITER_W-1:0] cfg_max_iter,
    output logic              load_en,
    output logic              cnu_en,
    output logic              vnu_en,
    input  logic              parity_ok,
    output logic [ITER_W-1:0] roop,
    output logic              o_val,
    input  logic              o_rdy,
    output logic              o_success,
    output logic [ITER_W-1:0] o_iter
);

`ifdef LDPC_EARLY_TERM_EN
    localparam bit c_early_term = 1'b1;
`else
    localparam bit c_early_term = 1'b0;
`endif

    localparam int unsigned c_cnt_w = phase_cnt_w(CNU_LAT, VNU_LAT, PAR_LAT);
    localparam logic [c_cnt_w-1:0] c_cnu_ld = c_cnt_w'(CNU_LAT - 1);
    localparam logic [c_cnt_w-1:0] c_vnu_ld = c_cnt_w'(VNU_LAT - 1);
    localparam logic [c_cnt_w-1:0] c_par_ld = c_cnt_w'(PAR_LAT - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_tmr_load;
    logic [c_cnt_w-1:0]  w_tmr_val;
    logic                w_tmr_zero;
    logic                w_accept;
    logic                w_chk_end;
    logic                w_done;
    logic [ITER_W-1:0]   w_lim;
    logic [ITER_W-1:0]   r_lim;
    logic [ITER_W-1:0]   w_roop_inc;
    logic                w_i_rdy_nxt;
    logic                w_load_en_nxt;
    logic                w_cnu_en_nxt;
    logic                w_vnu_en_nxt;
    logic                w_o_val_nxt;

    assign w_accept   = (r_state == S_IDLE) && i_val && i_rdy;
    assign w_roop_inc = roop + 1'b1;
    assign w_chk_end  = (r_state == S_CHK) && w_tmr_zero;
    assign w_done     = (w_roop_inc == r_lim) || (c_early_term && parity_ok);

    // Zero requests one iteration; anything above MAX_ITER is clamped.
    always_comb begin
        if (cfg_max_iter == '0) begin
            w_lim = ITER_W'(1);
        end else if (cfg_max_iter > ITER_W'(MAX_ITER)) begin
            w_lim = ITER_W'(MAX_ITER);
        end else begin
            w_lim = cfg_max_iter;
        end
    end

    ldpc_phase_timer #(
        .CNT_W (c_cnt_w)
    ) u_timer (
        .clk        (clk),
        .rst        (xrst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (xrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the timer is loaded on the last cycle of the
    // preceding state so each phase starts with count = latency-1.
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_val   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_state_nxt = S_CNU;
                w_tmr_load  = 1'b1;
                w_tmr_val   = c_cnu_ld;
            end
            S_CNU: begin
                if (w_tmr_zero) begin
                    w_state_nxt = S_VNU;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = c_vnu_ld;
                end
            end
            S_VNU: begin
                if (w_tmr_zero) begin
                    w_state_nxt = S_CHK;
                    w_tmr_load  = 1'b1;
                    w_tmr_val   = c_par_ld;
                end
            end
            S_CHK: begin
                if (w_tmr_zero) begin
                    if (w_done) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_CNU;
                        w_tmr_load  = 1'b1;
                        w_tmr_val   = c_cnu_ld;
                    end
                end
            end
            S_DONE: begin
                if (o_val && o_rdy) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state, so the registered outputs line up
    // with the state they describe and read as zero while in reset.
    always_comb begin
        w_i_rdy_nxt   = (w_state_nxt == S_IDLE);
        w_load_en_nxt = (w_state_nxt == S_LOAD);
        w_cnu_en_nxt  = (w_state_nxt == S_CNU);
        w_vnu_en_nxt  = (w_state_nxt == S_VNU);
        w_o_val_nxt   = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (xrst) begin
            i_rdy   <= 1'b0;
            load_en <= 1'b0;
            cnu_en  <= 1'b0;
            vnu_en  <= 1'b0;
            o_val   <= 1'b0;
        end else begin
            i_rdy   <= w_i_rdy_nxt;
            load_en <= w_load_en_nxt;
            cnu_en  <= w_cnu_en_nxt;
            vnu_en  <= w_vnu_en_nxt;
            o_val   <= w_o_val_nxt;
        end
    end

    // Iteration bookkeeping and result capture.
    always_ff @(posedge clk) begin
        if (xrst) begin
            r_lim     <= '0;
            roop      <= '0;
            o_success <= 1'b0;
            o_iter    <= '0;
        end else if (w_accept) begin
            r_lim <= w_lim;
            roop  <= '0;
        end else if (w_chk_end) begin
            if (w_done) begin
                o_success <= parity_ok;
                o_iter    <= w_roop_inc;
            end else begin
                roop <= w_roop_inc;
            end
        end
    end

endmodule
`default_nettype wire
